// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter/receiver state encoding and default frame geometry.
package uart_pkg;

  localparam int unsigned UART_CLK_DIV_NUMBER      = 10;
  localparam int unsigned UART_SINGLE_FRAME_LENGTH = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    SENDING   = 2'd2,
    STOP_BIT  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// CPU-side write handshake and serial line of the UART transmitter.
interface uart_tx_if;

  logic [7:0] cpu_to_uart_buf;
  logic       write_req;
  logic       ready;
  logic       busy;
  logic       uart_out;
  logic       write_int;

  modport master (
    output cpu_to_uart_buf, write_req,
    input  ready, busy, uart_out, write_int
  );

  modport slave (
    input  cpu_to_uart_buf, write_req,
    output ready, busy, uart_out, write_int
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts clk cycles, ticks on the last cycle of a bit, restarts on clr_i.
module uart_baud_gen #(
  parameter int unsigned CLK_DIV_NUMBER = uart_pkg::UART_CLK_DIV_NUMBER
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o
);

  logic [7:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == 8'(CLK_DIV_NUMBER - 1));

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, SINGLE_FRAME_LENGTH data bits LSB first, one stop bit.
// Define UART_TX_HOLD_EN to add a one-byte holding register for back-to-back frames.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV_NUMBER      = UART_CLK_DIV_NUMBER,
  parameter int unsigned SINGLE_FRAME_LENGTH = UART_SINGLE_FRAME_LENGTH
) (
  input logic      clk,
  input logic      rst_n,
  uart_tx_if.slave tx
);

  localparam int unsigned SW = (SINGLE_FRAME_LENGTH > 8) ? SINGLE_FRAME_LENGTH : 8;

  uart_state_e   state_q, state_d;
  logic [SW-1:0] shift_q, shift_d;
  logic [7:0]    bit_cnt_q, bit_cnt_d;
  logic          uart_out_q, uart_out_d;
  logic          write_int_q, write_int_d;
  logic          rst_done_q;
  logic          tick, clr, advance, accept;
`ifdef UART_TX_HOLD_EN
  logic [7:0]    hold_q, hold_d;
  logic          hold_valid_q, hold_valid_d;
`endif

  uart_baud_gen #(.CLK_DIV_NUMBER(CLK_DIV_NUMBER)) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (clr),
    .tick_o (tick)
  );

`ifdef UART_TX_HOLD_EN
  assign tx.ready = rst_done_q && !hold_valid_q;
`else
  assign tx.ready = rst_done_q && (state_q == IDLE);
`endif
  assign accept       = tx.write_req && tx.ready;
  assign tx.busy      = (state_q != IDLE);
  assign tx.uart_out  = uart_out_q;
  assign tx.write_int = write_int_q;
  assign clr          = (state_d != state_q) || advance || (state_q == IDLE);

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    uart_out_d  = uart_out_q;
    write_int_d = 1'b0;
    advance     = 1'b0;
`ifdef UART_TX_HOLD_EN
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
`endif
    case (state_q)
      IDLE: begin
        uart_out_d = 1'b1;
        bit_cnt_d  = '0;
`ifdef UART_TX_HOLD_EN
        if (hold_valid_q) begin
          state_d      = START_BIT;
          shift_d      = SW'(hold_q);
          hold_valid_d = 1'b0;
          uart_out_d   = 1'b0;
        end else
`endif
        if (accept) begin
          state_d    = START_BIT;
          shift_d    = SW'(tx.cpu_to_uart_buf);
          uart_out_d = 1'b0;
        end
      end
      START_BIT: if (tick) begin
        state_d    = SENDING;
        uart_out_d = shift_q[0];
        shift_d    = shift_q >> 1;
        bit_cnt_d  = '0;
      end
      SENDING: if (tick) begin
        if (bit_cnt_q == 8'(SINGLE_FRAME_LENGTH - 1)) begin
          state_d    = STOP_BIT;
          uart_out_d = 1'b1;
        end else begin
          uart_out_d = shift_q[0];
          shift_d    = shift_q >> 1;
          bit_cnt_d  = bit_cnt_q + 8'd1;
          advance    = 1'b1;
        end
      end
      STOP_BIT: if (tick) begin
        write_int_d = 1'b1;
        state_d     = IDLE;
`ifdef UART_TX_HOLD_EN
        // Chain straight into the next start bit so pending data leaves no idle gap.
        if (hold_valid_q) begin
          state_d      = START_BIT;
          shift_d      = SW'(hold_q);
          hold_valid_d = 1'b0;
          uart_out_d   = 1'b0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
`ifdef UART_TX_HOLD_EN
    if (accept && (state_q != IDLE)) begin
      hold_d       = tx.cpu_to_uart_buf;
      hold_valid_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      uart_out_q   <= 1'b1;
      write_int_q  <= 1'b0;
      rst_done_q   <= 1'b0;
`ifdef UART_TX_HOLD_EN
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      uart_out_q   <= uart_out_d;
      write_int_q  <= write_int_d;
      rst_done_q   <= 1'b1;
`ifdef UART_TX_HOLD_EN
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: line waveform per bit, write_int timing, loopback receiver,
// write-while-busy, level write_req, and mid-frame reset.
module tb_uart_tx;

  localparam int unsigned DIV = 10;
`ifdef UART_TX_HOLD_EN
  localparam int HOLD = 1;
`else
  localparam int HOLD = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  int   int_cnt = 0;
  int   rx_cnt = 0;
  logic [7:0] rx_byte = '0;
  int   n0, r0;

  uart_tx_if bus ();

  uart_tx #(.CLK_DIV_NUMBER(DIV), .SINGLE_FRAME_LENGTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tx    (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.write_int) int_cnt <= int_cnt + 1;

  // Independent mid-bit sampling receiver on the serial line.
  int         rx_t;
  logic       rx_busy;
  logic [7:0] rx_sh;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_busy <= 1'b0;
      rx_t    <= 0;
    end else if (!rx_busy) begin
      if (bus.uart_out == 1'b0) begin
        rx_busy <= 1'b1;
        rx_t    <= 2;
      end
    end else begin
      rx_t <= rx_t + 1;
      if (rx_t == 6 && bus.uart_out != 1'b0) rx_busy <= 1'b0;
      else if (rx_t >= 16 && rx_t <= 86 && (rx_t - 16) % 10 == 0)
        rx_sh[(rx_t - 16) / 10] <= bus.uart_out;
      else if (rx_t == 96) begin
        rx_busy <= 1'b0;
        if (bus.uart_out) begin
          rx_byte <= rx_sh;
          rx_cnt  <= rx_cnt + 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic fbit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return d[k-1];
  endfunction

  // Called at a negedge; requests a write that the next posedge accepts.
  task automatic do_write(input logic [7:0] d);
    bus.cpu_to_uart_buf = d;
    bus.write_req       = 1'b1;
    @(negedge clk);
    bus.write_req       = 1'b0;
  endtask

  // Entered at sample 1 (first negedge after the frame's first edge); leaves at sample 101.
  task automatic expect_frame(input logic [7:0] d, input int inj_from, input int inj_to,
                              input logic [7:0] inj_d, input int rdy_at50);
    for (int s = 1; s <= 100; s++) begin
      check($sformatf("%02h line s%0d", d, s), 32'(bus.uart_out), 32'(fbit(d, (s - 1) / 10)));
      if (s >= 2) check($sformatf("%02h write_int s%0d", d, s), 32'(bus.write_int), 0);
      if (s == 50) begin
        check($sformatf("%02h busy mid", d), 32'(bus.busy), 1);
        if (rdy_at50 >= 0) check($sformatf("%02h ready mid", d), 32'(bus.ready), 32'(rdy_at50));
      end
      if (s >= inj_from && s < inj_to) begin
        bus.write_req       = 1'b1;
        bus.cpu_to_uart_buf = inj_d;
      end else begin
        bus.write_req       = 1'b0;
        bus.cpu_to_uart_buf = 8'(s * 7);
      end
      @(negedge clk);
    end
    bus.write_req = 1'b0;
  endtask

  task automatic idle_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s idle line %0d", tag, i), 32'(bus.uart_out), 1);
      check($sformatf("%s idle busy %0d", tag, i), 32'(bus.busy), 0);
      check($sformatf("%s idle int %0d", tag, i), 32'(bus.write_int), 0);
      @(negedge clk);
    end
  endtask

  task automatic single_frame(input logic [7:0] d, input string tag);
    n0 = int_cnt;
    r0 = rx_cnt;
    do_write(d);
    expect_frame(d, 0, 0, 8'h00, HOLD);
    check({tag, " write_int@101"}, 32'(bus.write_int), 1);
    check({tag, " busy@101"}, 32'(bus.busy), 0);
    @(negedge clk);
    check({tag, " write_int@102"}, 32'(bus.write_int), 0);
    idle_check(tag, 3);
    check({tag, " int count"}, 32'(int_cnt - n0), 1);
    check({tag, " rx count"}, 32'(rx_cnt - r0), 1);
    check({tag, " rx byte"}, 32'(rx_byte), 32'(d));
  endtask

  initial begin
    rst_n               = 1'b0;
    bus.write_req       = 1'b0;
    bus.cpu_to_uart_buf = '0;
    repeat (3) @(negedge clk);
    check("rst line", 32'(bus.uart_out), 1);
    check("rst busy", 32'(bus.busy), 0);
    check("rst ready", 32'(bus.ready), 0);
    check("rst write_int", 32'(bus.write_int), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready after release", 32'(bus.ready), 1);
    idle_check("post-rst", 3);

    single_frame(8'hA5, "A5");
    single_frame(8'h3C, "3C");

`ifndef UART_TX_HOLD_EN
    // Second write during a frame is ignored; buffer changes do not disturb the line.
    n0 = int_cnt; r0 = rx_cnt;
    do_write(8'h11);
    expect_frame(8'h11, 5, 6, 8'h22, 0);
    check("11 write_int@101", 32'(bus.write_int), 1);
    @(negedge clk);
    idle_check("after11", 30);
    check("11 int count", 32'(int_cnt - n0), 1);
    check("11 rx count", 32'(rx_cnt - r0), 1);
    check("11 rx byte", 32'(rx_byte), 32'h11);

    // write_req held for three cycles in IDLE yields a single frame.
    n0 = int_cnt; r0 = rx_cnt;
    bus.cpu_to_uart_buf = 8'h81;
    bus.write_req       = 1'b1;
    @(negedge clk);
    expect_frame(8'h81, 1, 3, 8'h81, 0);
    check("81 write_int@101", 32'(bus.write_int), 1);
    @(negedge clk);
    idle_check("after81", 30);
    check("81 int count", 32'(int_cnt - n0), 1);
    check("81 rx count", 32'(rx_cnt - r0), 1);
`else
    // Write while busy goes to hold; frames run back to back.
    n0 = int_cnt; r0 = rx_cnt;
    do_write(8'h55);
    expect_frame(8'h55, 5, 6, 8'hAA, 0);
    check("55 write_int@101", 32'(bus.write_int), 1);
    check("55 ready@101", 32'(bus.ready), 1);
    check("55 busy@101", 32'(bus.busy), 1);
    expect_frame(8'hAA, 0, 0, 8'h00, 1);
    check("AA write_int@201", 32'(bus.write_int), 1);
    check("AA busy@201", 32'(bus.busy), 0);
    @(negedge clk);
    idle_check("afterAA", 5);
    check("55AA int count", 32'(int_cnt - n0), 2);
    check("55AA rx count", 32'(rx_cnt - r0), 2);
    check("55AA rx byte", 32'(rx_byte), 32'hAA);

    // Write in the last stop-bit cycle: one idle-high cycle, then the held frame.
    n0 = int_cnt; r0 = rx_cnt;
    do_write(8'h12);
    expect_frame(8'h12, 100, 101, 8'h34, 1);
    check("12 write_int@101", 32'(bus.write_int), 1);
    check("12 gap line", 32'(bus.uart_out), 1);
    check("12 gap busy", 32'(bus.busy), 0);
    @(negedge clk);
    expect_frame(8'h34, 0, 0, 8'h00, 1);
    check("34 write_int", 32'(bus.write_int), 1);
    @(negedge clk);
    idle_check("after34", 5);
    check("1234 int count", 32'(int_cnt - n0), 2);
    check("1234 rx byte", 32'(rx_byte), 32'h34);
`endif

    // Reset during data bit 3 abandons the frame immediately.
    n0 = int_cnt; r0 = rx_cnt;
    do_write(8'h37);
    repeat (44) @(negedge clk);
    check("pre-rst bit3", 32'(bus.uart_out), 0);
    #1 rst_n = 1'b0;
    #1;
    check("async rst line", 32'(bus.uart_out), 1);
    check("async rst busy", 32'(bus.busy), 0);
    check("async rst ready", 32'(bus.ready), 0);
    check("async rst write_int", 32'(bus.write_int), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready after mid rst", 32'(bus.ready), 1);
    idle_check("abort", 80);
    check("abort int count", 32'(int_cnt - n0), 0);
    check("abort rx count", 32'(rx_cnt - r0), 0);
    single_frame(8'h0F, "0F");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
